// File: rtl/scrub_scheduler_if.sv
// rtl/scrub_scheduler_if.sv - per-bank scrub request/ack/error bundle
// Purpose: groups the scrub handshake between the scheduler and the banks.
// Signals (NUM_BANKS wide each):
//   scrub_req_o  one-hot request, driven by the scheduler (master)
//   scrub_ack_i  per-bank scrub-complete strobe, driven by the banks (slave)
//   scrub_err_i  per-bank corrected-flip flag, valid only with that bank's ack
interface scrub_scheduler_if #(
  parameter int NUM_BANKS = 4
);
  logic [NUM_BANKS-1:0] scrub_req_o;
  logic [NUM_BANKS-1:0] scrub_ack_i;
  logic [NUM_BANKS-1:0] scrub_err_i;

  modport master (
    output scrub_req_o,
    input  scrub_ack_i,
    input  scrub_err_i
  );

  modport slave (
    input  scrub_req_o,
    output scrub_ack_i,
    output scrub_err_i
  );
endinterface

// File: rtl/scrub_scheduler.sv
// rtl/scrub_scheduler.sv - round-robin scrub sequencer with req/ack timeout
// Purpose: requests a scrub from each bank in turn, spaced by an idle period,
// and turns each completed scrub into a one-cycle error pulse on its lane.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   enable_i          run the scrub sequence while high
//   period_i          idle cycles between requests (sampled on WAIT entry)
//   bank_if           scrub req/ack/err bundle (master side)
//   err_flag_o        one-cycle pulse on the lane of a bank reporting an error
//   timeout_o         one-cycle pulse when a request is abandoned
//   round_done_o      one-cycle pulse when the last bank finishes
//   bank_idx_o        current bank index
//   pass_cnt_o        completed rounds, saturating at 0xFFFF
//   busy_o            high whenever the sequencer is not idle
module scrub_scheduler #(
  parameter int NUM_BANKS = 4,
  parameter int PERIOD_W  = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic [PERIOD_W-1:0]          period_i,
  scrub_scheduler_if.master            bank_if,
  output logic [NUM_BANKS-1:0]         err_flag_o,
  output logic                         timeout_o,
  output logic                         round_done_o,
  output logic [$clog2(NUM_BANKS)-1:0] bank_idx_o,
  output logic [15:0]                  pass_cnt_o,
  output logic                         busy_o
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REQ  = 2'd2,
    S_NEXT = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [PERIOD_W-1:0]  period_cnt_q, period_cnt_d;
  logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [BW-1:0]        bank_idx_q, bank_idx_d;
  logic [15:0]          pass_cnt_q, pass_cnt_d;
  logic [NUM_BANKS-1:0] err_flag_q, err_flag_d;
  logic                 timeout_q, timeout_d;
  logic                 round_done_q, round_done_d;

  logic [NUM_BANKS-1:0] bank_mask;
  logic                 ack_cur;
  logic                 tmo_hit;
  logic                 last_bank;

  // One-hot lane of the current bank; acks/errors outside it are ignored.
  assign bank_mask = {{(NUM_BANKS-1){1'b0}}, 1'b1} << bank_idx_q;
  assign ack_cur   = |(bank_if.scrub_ack_i & bank_mask);
  assign tmo_hit   = (tmo_cnt_q == TW'(TIMEOUT - 1));
  assign last_bank = (bank_idx_q == BW'(NUM_BANKS - 1));

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      period_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      bank_idx_q   <= '0;
      pass_cnt_q   <= '0;
      err_flag_q   <= '0;
      timeout_q    <= 1'b0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      bank_idx_q   <= bank_idx_d;
      pass_cnt_q   <= pass_cnt_d;
      err_flag_q   <= err_flag_d;
      timeout_q    <= timeout_d;
      round_done_q <= round_done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enable_i) state_d = S_WAIT;
      S_WAIT: begin
        if (!enable_i)                         state_d = S_IDLE;
        else if (period_cnt_q <= PERIOD_W'(1)) state_d = S_REQ;
      end
      // enable_i is deliberately ignored here: an issued request must finish.
      S_REQ:  if (ack_cur || tmo_hit) state_d = S_NEXT;
      S_NEXT: state_d = enable_i ? S_WAIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values and registered pulses.
  always_comb begin
    period_cnt_d = period_cnt_q;
    tmo_cnt_d    = '0;
    bank_idx_d   = bank_idx_q;
    pass_cnt_d   = pass_cnt_q;
    err_flag_d   = '0;
    timeout_d    = 1'b0;
    round_done_d = 1'b0;
    case (state_q)
      S_IDLE: if (enable_i) period_cnt_d = period_i;
      S_WAIT: begin
        if (enable_i && period_cnt_q > PERIOD_W'(1)) period_cnt_d = period_cnt_q - PERIOD_W'(1);
      end
      S_REQ: begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        // Ack is checked first so an ack on the final cycle beats the timeout.
        if (ack_cur) begin
          err_flag_d   = bank_if.scrub_err_i & bank_mask;
          round_done_d = last_bank;
        end else if (tmo_hit) begin
          timeout_d    = 1'b1;
          round_done_d = last_bank;
        end
      end
      S_NEXT: begin
        bank_idx_d = last_bank ? '0 : bank_idx_q + BW'(1);
        if (last_bank && pass_cnt_q != 16'hFFFF) pass_cnt_d = pass_cnt_q + 16'd1;
        if (enable_i) period_cnt_d = period_i;
      end
      default: ;
    endcase
  end

  // Outputs, decoded from registers only.
  always_comb begin
    bank_if.scrub_req_o = (state_q == S_REQ) ? bank_mask : '0;
    busy_o              = (state_q != S_IDLE);
  end

  assign err_flag_o   = err_flag_q;
  assign timeout_o    = timeout_q;
  assign round_done_o = round_done_q;
  assign bank_idx_o   = bank_idx_q;
  assign pass_cnt_o   = pass_cnt_q;

endmodule

// File: tb/tb_scrub_scheduler.sv
// tb/tb_scrub_scheduler.sv - directed self-checking bench for scrub_scheduler
module tb_scrub_scheduler;
  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] period;
  logic [NB-1:0] err_flag;
  logic        timeout;
  logic        round_done;
  logic [1:0]  bank_idx;
  logic [15:0] pass_cnt;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  scrub_scheduler_if #(.NUM_BANKS(NB)) bif ();

  scrub_scheduler #(
    .NUM_BANKS(NB),
    .PERIOD_W (16),
    .TIMEOUT  (64)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .period_i    (period),
    .bank_if     (bif),
    .err_flag_o  (err_flag),
    .timeout_o   (timeout),
    .round_done_o(round_done),
    .bank_idx_o  (bank_idx),
    .pass_cnt_o  (pass_cnt),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input string tag, input logic [3:0] exp, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bif.scrub_req_o == '0 && cyc < 200);
    check(tag, 32'(bif.scrub_req_o), 32'(exp));
  endtask

  // Wait for the expected request, ack it dly cycles later, check the NEXT cycle.
  task automatic serve(input string tag, input logic [3:0] exp, input logic errb,
                       input logic last, input int dly, output int cyc);
    wait_req({tag, "_req"}, exp, cyc);
    repeat (dly) @(negedge clk);
    bif.scrub_ack_i = exp;
    bif.scrub_err_i = errb ? exp : 4'b0000;
    @(negedge clk);
    bif.scrub_ack_i = '0;
    bif.scrub_err_i = '0;
    check({tag, "_err_pulse"}, 32'(err_flag), errb ? 32'(exp) : 32'd0);
    check({tag, "_req_drop"}, 32'(bif.scrub_req_o), 32'd0);
    check({tag, "_round_done"}, 32'(round_done), 32'(last));
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'({err_flag, round_done}), 32'd0);
  endtask

  initial begin
    int          cyc;
    logic [31:0] acc;
    logic [3:0]  m;

    rst = 1'b1;
    enable = 1'b0;
    period = 16'd3;
    bif.scrub_ack_i = '0;
    bif.scrub_err_i = '0;

    // Reset and idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    acc = '0;
    repeat (10) begin
      @(negedge clk);
      acc |= 32'({bif.scrub_req_o, err_flag, timeout, round_done, bank_idx, pass_cnt, busy});
    end
    check("reset_outputs", acc, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Basic round, period 3, ack 2 cycles after each request
    enable = 1'b1;
    serve("r1b0", 4'b0001, 1'b0, 1'b0, 2, cyc);
    check("first_req_latency", 32'(cyc), 32'd4);
    serve("r1b1", 4'b0010, 1'b0, 1'b0, 2, cyc);
    check("req_spacing", 32'(cyc), 32'd3);
    serve("r1b2", 4'b0100, 1'b1, 1'b0, 2, cyc);
    serve("r1b3", 4'b1000, 1'b0, 1'b1, 2, cyc);
    check("pass_after_r1", 32'(pass_cnt), 32'd1);

    // Timeout on bank 1, then ack on the final REQ cycle for bank 2
    serve("r2b0", 4'b0001, 1'b0, 1'b0, 2, cyc);
    wait_req("tmo_req", 4'b0010, cyc);
    repeat (63) @(negedge clk);
    check("tmo_not_early", 32'({timeout, bif.scrub_req_o}), 32'h02);
    @(negedge clk);
    check("tmo_pulse", 32'(timeout), 32'd1);
    check("tmo_no_err", 32'(err_flag), 32'd0);
    check("tmo_req_drop", 32'(bif.scrub_req_o), 32'd0);
    @(negedge clk);
    check("tmo_pulse_end", 32'(timeout), 32'd0);
    serve("late_ack", 4'b0100, 1'b0, 1'b0, 63, cyc);
    serve("r2b3", 4'b1000, 1'b0, 1'b1, 2, cyc);
    check("pass_after_r2", 32'(pass_cnt), 32'd2);

    // Disable during WAIT
    enable = 1'b0;
    @(negedge clk);
    check("dis_wait_idle", 32'({busy, bif.scrub_req_o}), 32'd0);
    repeat (5) @(negedge clk);
    check("dis_idle_hold", 32'({busy, bif.scrub_req_o, bank_idx}), 32'd0);

    // Disable during REQ: request still completes, then IDLE with index held
    enable = 1'b1;
    wait_req("dis_req", 4'b0001, cyc);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    bif.scrub_ack_i = 4'b0001;
    @(negedge clk);
    bif.scrub_ack_i = '0;
    check("dis_next_busy", 32'({busy, bif.scrub_req_o}), 32'h10);
    @(negedge clk);
    check("dis_idle_after_next", 32'(busy), 32'd0);
    check("dis_idx_held", 32'(bank_idx), 32'd1);
    repeat (4) @(negedge clk);
    check("dis_no_new_req", 32'({busy, bif.scrub_req_o}), 32'd0);

    // Zero period and stray acks/errors on other banks
    period = 16'd0;
    enable = 1'b1;
    wait_req("z_req1", 4'b0010, cyc);
    check("z_latency", 32'(cyc), 32'd2);
    bif.scrub_ack_i = 4'b1101;
    bif.scrub_err_i = 4'b1101;
    repeat (3) @(negedge clk);
    check("stray_req_held", 32'(bif.scrub_req_o), 32'h2);
    check("stray_no_err", 32'(err_flag), 32'd0);
    bif.scrub_ack_i = 4'b1111;
    bif.scrub_err_i = 4'b1101;
    @(negedge clk);
    bif.scrub_ack_i = '0;
    bif.scrub_err_i = '0;
    check("stray_next_err", 32'(err_flag), 32'd0);
    check("stray_req_drop", 32'(bif.scrub_req_o), 32'd0);
    serve("z_b2", 4'b0100, 1'b0, 1'b0, 0, cyc);
    check("z_wait_one", 32'(cyc), 32'd2);
    serve("z_b3", 4'b1000, 1'b0, 1'b1, 0, cyc);
    check("pass_after_r3", 32'(pass_cnt), 32'd3);

    // Saturation of the pass counter
    enable = 1'b0;
    @(negedge clk);
    force dut.pass_cnt_q = 16'hFFFE;
    repeat (2) @(negedge clk);
    release dut.pass_cnt_q;
    @(negedge clk);
    check("sat_preload", 32'(pass_cnt), 32'h0000FFFE);
    enable = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < 4; b++) begin
        m = 4'b0001 << b;
        serve($sformatf("sat_r%0d_b%0d", r, b), m, 1'b0, (b == 3), 0, cyc);
      end
      check($sformatf("sat_pass_r%0d", r), 32'(pass_cnt), 32'h0000FFFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/scrub_scheduler.md
# scrub_scheduler

Round-robin scrub sequencer for the bit-flip monitor. It issues one scrub request at a time to each of NUM_BANKS memory banks, spacing requests by a programmable idle period, and handles the per-bank req/ack handshake with a timeout. Each completed scrub produces a one-cycle error-flag pulse on the bank's lane. That vector is the scrub input of the bit-flip rate monitor, so this block sits between the protected memories and the monitor.

## Interface
Parameters:
- NUM_BANKS, 4: number of scrubbed banks. Minimum 2. Equals the monitor's input scrub width.
- PERIOD_W, 16: width of the scrub period value.
- TIMEOUT, 64: maximum REQ cycles without an ack before the bank is abandoned. Minimum 2.

Ports:
- clk_i, input, 1: single clock for the whole block.
- rst_i, input, 1: synchronous, active-high reset.
- enable_i, input, 1: run the scrub sequence while high.
- period_i, input, PERIOD_W: idle cycles between consecutive requests.
- scrub_req_o, output, NUM_BANKS: one-hot request to the current bank.
- scrub_ack_i, input, NUM_BANKS: per-bank scrub-complete strobe.
- scrub_err_i, input, NUM_BANKS: per-bank "bit flip corrected" flag. Valid only together with that bank's ack.
- err_flag_o, output, NUM_BANKS: registered one-cycle pulse on the lane of a bank that reported an error.
- timeout_o, output, 1: one-cycle pulse when a request is abandoned.
- round_done_o, output, 1: one-cycle pulse when bank NUM_BANKS-1 finishes.
- bank_idx_o, output, $clog2(NUM_BANKS): current bank index.
- pass_cnt_o, output, 16: completed rounds, saturating at 0xFFFF.
- busy_o, output, 1: high in any state other than IDLE.

## Operation
- Reset: state IDLE, bank index 0, pass count 0, period and timeout counters 0. All outputs are 0.
- States are IDLE, WAIT, REQ and NEXT.
- IDLE:
  - All request and pulse outputs are low.
  - enable_i high moves to WAIT and loads the period counter with period_i.
- WAIT:
  - enable_i low returns to IDLE immediately, with no request issued.
  - Otherwise, if the counter is ≤1, go to REQ; else decrement.
  - WAIT therefore lasts max(period_i,1) cycles.
  - period_i is sampled only on WAIT entry.
- REQ:
  - scrub_req_o[bank_idx_o] = 1; all other bits are 0.
  - The timeout counter starts at 0 on entry and increments each cycle.
  - Ack on the current bank:
    - go to NEXT;
    - err_flag_o[idx] <= scrub_err_i[idx].
  - No ack while the timeout counter equals TIMEOUT-1:
    - go to NEXT;
    - timeout_o <= 1;
    - err_flag_o stays 0.
  - An ack on the final cycle wins over the timeout.
  - Acks and errors on non-current banks are ignored.
  - enable_i is not checked in REQ; an outstanding request always completes or times out.
- NEXT (exactly 1 cycle):
  - Bank index increments and wraps from NUM_BANKS-1 to 0.
  - On the wrap, round_done_o is asserted and pass_cnt_o increments, saturating at 0xFFFF.
  - If enable_i is low, go to IDLE. Otherwise go to WAIT and reload the period counter with period_i.
  - Bank index and pass count are kept across IDLE; only rst_i clears them.
- A timed-out bank still advances the round, and still counts toward round_done_o.

## Timing
- scrub_req_o, busy_o and bank_idx_o are decoded from registers; there is no input-to-output combinational path.
- err_flag_o, timeout_o and round_done_o are registered and each lasts exactly one cycle, in the cycle after the deciding REQ cycle (the first NEXT cycle).
- scrub_req_o deasserts in that same cycle.
- Example, period_i=3, enable_i rising in cycle 0:
  - WAIT in cycles 1–3;
  - req high from cycle 4;
  - ack in cycle 6 → err pulse and NEXT in cycle 7;
  - WAIT from cycle 8.
- Minimum spacing between requests is 3 cycles: REQ, NEXT, WAIT.
- Timeout: REQ entered in cycle t with no ack gives NEXT and timeout_o in cycle t+TIMEOUT.
- rst_i mid-REQ drops scrub_req_o in the next cycle and returns all state to reset values. No pulses are emitted.

## Test plan
- Reset check: rst_i high 2 cycles, then enable_i=0 for 10 cycles → all outputs 0, busy_o=0.
- Basic round, NUM_BANKS=4, period_i=3:
  - Stimulus: ack 2 cycles after each req; scrub_err_i set only for bank 2.
  - Required: req order 0001, 0010, 0100, 1000.
  - Required: err_flag_o=0100 for exactly one cycle.
  - Required: round_done_o pulses once; pass_cnt_o=1.
- Timeout, TIMEOUT=64:
  - Stimulus: never ack bank 1.
  - Required: timeout_o in cycle t+64; no err_flag_o; bank 2 is requested next.
  - Ack in cycle t+63 → no timeout_o.
- Disable:
  - enable_i low during WAIT → IDLE next cycle, no request.
  - enable_i low during REQ → request completes on ack, then IDLE after NEXT; bank_idx_o is held.
- Stray acks and zero period:
  - Stimulus: period_i=0; ack/err on non-current banks.
  - Required: WAIT lasts 1 cycle; stray acks ignored; no err_flag_o.
- Saturation:
  - Stimulus: preload pass count near 0xFFFF (force) and run 3 rounds.
  - Required: pass_cnt_o holds 0xFFFF; round_done_o still pulses each round.
